// File: rtl/spi_master_frame.sv
// rtl/spi_master_frame.sv - SPI master shifting one {rw, addr, data} frame per transaction
//
// Purpose:
//   Shifts one command frame, MSB first: a R/W bit, ADDR_W address bits and
//   DATA_W data bits (F = 1 + ADDR_W + DATA_W). Supports all four CPOL/CPHA
//   modes and a programmable half-period divider. On read frames the data
//   field goes out as zeros, and the last DATA_W sampled miso bits land in
//   rd_data in the cycle done pulses.
//
// Parameters:
//   HALF_DIV  clk cycles per SCK half-period (>= 1)
//   ADDR_W    address bits per frame (>= 1)
//   DATA_W    data bits per frame (>= 1)
//   CPOL      SCK idle level
//   CPHA      0: sample on leading edge, 1: sample on trailing edge
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, aborts any frame in flight
//   start    in   transaction request, accepted only while busy = 0
//   rw       in   1 = read, 0 = write; first frame bit
//   addr_in  in   address, captured at accept
//   wr_data  in   write data, captured at accept
//   busy     out  high from the cycle after accept through the deselect gap
//   done     out  one-cycle pulse as cs_n rises
//   rd_data  out  last read data, updated only with done on read frames
//   miso     in   serial input
//   mosi     out  serial output
//   sck      out  serial clock
//   cs_n     out  chip select, active low

module spi_master_frame #(
    parameter int HALF_DIV = 50,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              cs_n
);

    localparam int F      = 1 + ADDR_W + DATA_W;
    localparam int EDGES  = 2 * F;
    localparam int DIV_W  = $clog2(HALF_DIV + 1);
    localparam int EDGE_W = $clog2(EDGES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES);
    localparam logic              SCK_IDLE  = 1'(CPOL);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        LAG,
        GAP
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [F-1:0]        tx_sh;
    logic [DATA_W-1:0]   rx_sh;
    logic                rw_q;

    logic                tick;
    logic [EDGE_W-1:0]   edge_next;
    logic                sample_now;
    logic                shift_now;
    logic [F-1:0]        frame;

    // One tick per SCK half-period; every phase is a whole number of these.
    assign tick      = (div_cnt == DIV_LAST);
    assign edge_next = edge_cnt + 1'b1;

    // Odd edge numbers are leading edges. CPHA picks which parity samples.
    assign sample_now = (CPHA == 0) ? edge_next[0] : ~edge_next[0];

    // The opposite edge moves mosi, except the final edge: for CPHA=0 the
    // last bit has already been presented and must hold until deselect.
    assign shift_now = ~sample_now && (edge_next != EDGE_LAST);

    // Read frames send a zero data field; the peripheral drives it instead.
    assign frame = {rw, addr_in, rw ? {DATA_W{1'b0}} : wr_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rw_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            mosi     <= 1'b0;
            sck      <= SCK_IDLE;
            cs_n     <= 1'b1;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (start) begin
                        state <= LEAD;
                        busy  <= 1'b1;
                        cs_n  <= 1'b0;
                        rw_q  <= rw;
                        if (CPHA == 0) begin
                            // First bit must be valid before the leading
                            // edge samples it, so present it with cs_n.
                            mosi  <= frame[F-1];
                            tx_sh <= frame << 1;
                        end else begin
                            // Edge 1 presents the first bit.
                            mosi  <= 1'b0;
                            tx_sh <= frame;
                        end
                    end
                end

                // LEAD covers the setup half-period; its closing tick is
                // SCK edge 1. SHIFT then runs edges 2..2F on each tick.
                LEAD, SHIFT: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt  <= '0;
                        sck      <= ~sck;
                        edge_cnt <= edge_next;
                        if (sample_now) begin
                            // Keep only the newest DATA_W samples; command
                            // and address phase bits fall off the top.
                            rx_sh <= DATA_W'({rx_sh, miso});
                        end else if (shift_now) begin
                            mosi  <= tx_sh[F-1];
                            tx_sh <= tx_sh << 1;
                        end
                        if (edge_next == EDGE_LAST) begin
                            state <= LAG;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                // Hold-time half-period after the last edge, then deselect.
                LAG: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        done    <= 1'b1;
                        if (rw_q) begin
                            rd_data <= rx_sh;
                        end
                        state <= GAP;
                    end
                end

                // Minimum cs_n high time before the next frame can start.
                GAP: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_frame.sv
// tb/tb_spi_master_frame.sv - scoreboard bench for spi_master_frame across modes and widths

module tb_spi_master_frame;

    localparam int N = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst, start, rw, miso, mosi, sck, cs_n, busy, done;
    logic [6:0]   addr    [N];
    logic [7:0]   wr_data [N];
    logic [7:0]   rd_data [N];
    logic [7:0]   resp    [N];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instances 0..3: HALF_DIV=2, 7/8 widths, mode = index. Instance 4: F=3, HALF_DIV=1.
    function automatic int p_a(int i);    return (i == 4) ? 1 : 7;         endfunction
    function automatic int p_d(int i);    return (i == 4) ? 1 : 8;         endfunction
    function automatic int p_cpol(int i); return (i == 4) ? 0 : (i >> 1) & 1; endfunction
    function automatic int p_cpha(int i); return (i == 4) ? 0 : i & 1;     endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int H  = (g == 4) ? 1 : 2;
        localparam int A  = (g == 4) ? 1 : 7;
        localparam int D  = (g == 4) ? 1 : 8;
        localparam int CP = (g == 4) ? 0 : (g >> 1) & 1;
        localparam int CH = (g == 4) ? 0 : g & 1;
        logic [D-1:0] rdw;
        spi_master_frame #(
            .HALF_DIV(H), .ADDR_W(A), .DATA_W(D), .CPOL(CP), .CPHA(CH)
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .start   (start[g]),
            .rw      (rw[g]),
            .addr_in (addr[g][A-1:0]),
            .wr_data (wr_data[g][D-1:0]),
            .busy    (busy[g]),
            .done    (done[g]),
            .rd_data (rdw),
            .miso    (miso[g]),
            .mosi    (mosi[g]),
            .sck     (sck[g]),
            .cs_n    (cs_n[g])
        );
        assign rd_data[g] = 8'(rdw);
    end

    typedef struct {
        int inst;
        int mosi;
        int chk_rd;
        int rd;
        int done_dly;
        int busy_dly;
        int gap;
    } exp_t;

    exp_t sbq[$];

    function automatic string nm(string s, int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic chk(string name, int act, int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // ---------------- slave model + monitor ----------------
    logic [N-1:0] sck_p, cs_p, mosi_p, busy_p;
    int cap [N], ncap [N], viol [N], ptr [N], rf [N];
    int t_fall [N], t_rise [N], pend_busy [N];
    bit pend [N];
    exp_t mon_e;
    int   f_m;
    bit   edg, lead, samp;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cyc >= 4) begin
                f_m  = 1 + p_a(i) + p_d(i);
                edg  = (sck[i] !== sck_p[i]);
                lead = edg && (sck_p[i] == 1'(p_cpol(i)));
                samp = edg && (lead == (p_cpha(i) == 0));

                if (cs_p[i] && !cs_n[i]) begin
                    t_fall[i] = cyc;
                    cap[i]    = 0;
                    ncap[i]   = 0;
                    viol[i]   = 0;
                    rf[i]     = int'(resp[i]) & ((1 << p_d(i)) - 1);
                    ptr[i]    = f_m - 1;
                    if (sbq.size() > 0 && sbq[0].inst == i && sbq[0].gap >= 0)
                        chk(nm("cs_high_gap", i), cyc - t_rise[i], sbq[0].gap);
                    if (p_cpha(i) == 0) begin
                        miso[i] = rf[i][ptr[i]];
                        ptr[i]--;
                    end
                end

                if (!cs_n[i] && edg) begin
                    if (samp) begin
                        cap[i] = (cap[i] << 1) | int'(mosi_p[i]);
                        ncap[i]++;
                        if (mosi[i] !== mosi_p[i]) viol[i]++;
                    end else if (ptr[i] >= 0) begin
                        miso[i] = rf[i][ptr[i]];
                        ptr[i]--;
                    end
                end

                if (done[i]) begin
                    if (sbq.size() == 0 || sbq[0].inst != i) begin
                        chk(nm("unexpected_done", i), 1, 0);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk(nm("mosi_frame", i), cap[i] & ((1 << f_m) - 1), mon_e.mosi);
                        chk(nm("bit_count", i), ncap[i], f_m);
                        chk(nm("mosi_stable_at_sample", i), viol[i], 0);
                        chk(nm("cs_rise_with_done", i), int'(cs_n[i] & ~cs_p[i]), 1);
                        chk(nm("done_latency", i), cyc - t_fall[i], mon_e.done_dly);
                        chk(nm("sck_idle_at_done", i), int'(sck[i]), p_cpol(i));
                        if (mon_e.chk_rd != 0)
                            chk(nm("rd_data", i), int'(rd_data[i]), mon_e.rd);
                        pend_busy[i] = mon_e.busy_dly;
                        pend[i]      = 1'b1;
                    end
                end

                if (busy_p[i] && !busy[i] && pend[i]) begin
                    chk(nm("busy_latency", i), cyc - t_fall[i], pend_busy[i]);
                    pend[i] = 1'b0;
                end

                if (!cs_p[i] && cs_n[i]) begin
                    t_rise[i] = cyc;
                    miso[i]   = 1'b0;
                end
            end
            sck_p[i]  = sck[i];
            cs_p[i]   = cs_n[i];
            mosi_p[i] = mosi[i];
            busy_p[i] = busy[i];
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_busy(int i, logic lvl, int budget, string what);
        int k = 0;
        while (busy[i] !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy[i] !== lvl) chk(nm({"timeout_", what}, i), 0, 1);
    endtask

    task automatic push_exp(int i, int m, int chk_rd, int rd, int gap);
        exp_t e;
        e.inst     = i;
        e.mosi     = m;
        e.chk_rd   = chk_rd;
        e.rd       = rd;
        e.done_dly = (i == 4) ? 7 : 66;
        e.busy_dly = (i == 4) ? 8 : 68;
        e.gap      = gap;
        sbq.push_back(e);
    endtask

    task automatic run_frame(int i, logic r, logic [6:0] a, logic [7:0] d, logic [7:0] rsp,
                             int exp_mosi, int chk_rd, int exp_rd);
        push_exp(i, exp_mosi, chk_rd, exp_rd, -1);
        resp[i]    = rsp;
        rw[i]      = r;
        addr[i]    = a;
        wr_data[i] = d;
        start[i]   = 1'b1;
        @(negedge clk);
        wait_busy(i, 1'b1, 4, "accept");
        start[i]   = 1'b0;
        rw[i]      = ~r;
        addr[i]    = ~a;
        wr_data[i] = ~d;
        wait_busy(i, 1'b0, 200, "frame_end");
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int edges;
        logic sp;

        rst   = '1;
        start = '0;
        rw    = '0;
        miso  = '0;
        for (int i = 0; i < N; i++) begin
            addr[i]    = '0;
            wr_data[i] = '0;
            resp[i]    = '0;
            pend[i]    = 1'b0;
            t_rise[i]  = 0;
        end
        repeat (4) @(negedge clk);
        rst = '0;
        @(negedge clk);

        for (int i = 0; i < N; i++) begin
            chk(nm("rst_cs_n", i), int'(cs_n[i]), 1);
            chk(nm("rst_sck", i), int'(sck[i]), p_cpol(i));
            chk(nm("rst_mosi", i), int'(mosi[i]), 0);
            chk(nm("rst_busy", i), int'(busy[i]), 0);
            chk(nm("rst_done", i), int'(done[i]), 0);
            chk(nm("rst_rd_data", i), int'(rd_data[i]), 0);
        end

        // Mode 0: write, read with wr_data ignored, write leaves rd_data alone.
        run_frame(0, 1'b0, 7'h2A, 8'hC3, 8'h00, 'h2AC3, 1, 'h00);
        run_frame(0, 1'b1, 7'h15, 8'hFF, 8'hA5, 'h9500, 1, 'hA5);
        run_frame(0, 1'b0, 7'h7F, 8'h01, 8'h00, 'h7F01, 1, 'hA5);

        // start pulse mid-frame must be dropped.
        push_exp(0, 'h0F5A, 0, 0, -1);
        rw[0] = 1'b0; addr[0] = 7'h0F; wr_data[0] = 8'h5A; start[0] = 1'b1;
        @(negedge clk);
        wait_busy(0, 1'b1, 4, "accept_ign");
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        addr[0] = 7'h70; wr_data[0] = 8'h11; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_busy(0, 1'b0, 200, "ign_end");
        repeat (20) @(negedge clk);
        chk("start_ignored_busy", int'(busy[0]), 0);
        chk("start_ignored_queue", sbq.size(), 0);

        // start held high: back-to-back frames, inputs changed after accept.
        push_exp(0, 'h1122, 1, 'hA5, -1);
        push_exp(0, 'h3344, 1, 'hA5, 3);
        rw[0] = 1'b0; addr[0] = 7'h11; wr_data[0] = 8'h22; start[0] = 1'b1;
        @(negedge clk);
        wait_busy(0, 1'b1, 4, "accept_h1");
        addr[0] = 7'h33; wr_data[0] = 8'h44;
        wait_busy(0, 1'b0, 200, "hold_gap");
        @(negedge clk);
        wait_busy(0, 1'b1, 4, "accept_h2");
        start[0] = 1'b0;
        wait_busy(0, 1'b0, 200, "hold_end");

        // Reset at edge 9 of a read.
        resp[0] = 8'h3C; rw[0] = 1'b1; addr[0] = 7'h15; start[0] = 1'b1;
        @(negedge clk);
        wait_busy(0, 1'b1, 4, "accept_rst");
        start[0] = 1'b0;
        k = 0; edges = 0; sp = sck[0];
        while (edges < 9 && k < 100) begin
            @(negedge clk);
            k++;
            if (sck[0] !== sp) edges++;
            sp = sck[0];
        end
        chk("edge9_reached", edges, 9);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", int'(cs_n[0]), 1);
        chk("abort_sck", int'(sck[0]), 0);
        chk("abort_mosi", int'(mosi[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_rd_data", int'(rd_data[0]), 0);
        rst[0] = 1'b0;
        repeat (80) @(negedge clk);
        run_frame(0, 1'b1, 7'h15, 8'h00, 8'h3C, 'h9500, 1, 'h3C);

        // Modes 1..3: read 0x5A, then a write that must keep rd_data.
        for (int i = 1; i <= 3; i++) begin
            run_frame(i, 1'b1, 7'h15, 8'h00, 8'h5A, 'h9500, 1, 'h5A);
            run_frame(i, 1'b0, 7'h2A, 8'hC3, 8'h00, 'h2AC3, 1, 'h5A);
        end

        // F=3, HALF_DIV=1.
        run_frame(4, 1'b0, 7'h01, 8'h00, 8'h00, 'h2, 0, 0);
        run_frame(4, 1'b1, 7'h01, 8'h00, 8'h01, 'h6, 1, 1);
        run_frame(4, 1'b0, 7'h00, 8'h01, 8'h00, 'h1, 1, 1);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
